// File: rtl/multi_edge_to_pulse.sv
// multi_edge_to_pulse: per-channel sync, mode-selected edge detect,
// and a fixed-length registered pulse with optional retrigger.
module multi_edge_to_pulse #(
  parameter int CHANNELS     = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int RETRIGGER    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] data_in,
  output logic [CHANNELS-1:0] data_out,
  output logic [CHANNELS-1:0] missed
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_e;

  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] p_q;
  logic [CHANNELS-1:0] e;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = data_in;
    end else begin : g_sync
      logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
          end
        end else begin
          sync_q[0] <= data_in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // History tracks even when disabled so re-enabling sees no stale edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q <= '0;
    end else begin
      p_q <= s;
    end
  end

  always_comb begin
    e = '0;
    case (mode)
      2'b00:   e = s & ~p_q;
      2'b01:   e = ~s & p_q;
      2'b10:   e = s ^ p_q;
      default: e = '0;
    endcase
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_e          state_q;
      state_e          state_d;
      logic [CW-1:0]   cnt_q;
      logic [CW-1:0]   cnt_d;
      logic            miss_q;
      logic            miss_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          miss_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          miss_q  <= miss_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = 1'b0;
        unique case (state_q)
          IDLE: begin
            if (e[i]) begin
              state_d = PULSE;
              cnt_d   = RELOAD;
            end
          end
          PULSE: begin
            if (e[i] && (RETRIGGER != 0)) begin
              cnt_d = RELOAD;
            end else begin
              miss_d = e[i];
              if (cnt_q == '0) begin
                state_d = IDLE;
              end else begin
                cnt_d = cnt_q - CW'(1);
              end
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign data_out[i] = (state_q == PULSE);
      assign missed[i]   = miss_q;
    end
  endgenerate

endmodule
